vector_alu_sequencer: RTL and testbench
=======================================

# vector_alu_sequencer

- Issue-side driver for the execute-stage scalar ALU.
- Accepts one vector operation, then walks its lanes through the ALU one element per cycle and collects the per-lane result and flags.
- Presents the completed result vector to writeback with a valid/ready handshake.
- Sits between decode/issue and writeback: it drives the ALU's select and operand inputs and consumes the ALU's result and flags.

## Interface
Parameters:
- dataSize, 8, element width in bits
- lanes, 4, elements per vector (≥2); lane 0 occupies the LSBs of every packed vector

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  issue request valid
- in_ready  out  1  sequencer can accept a request
- in_op  in  3  ALU operation code, forwarded unchanged to the ALU
- in_vec_a  in  lanes*dataSize  packed operand A vector
- in_vec_b  in  lanes*dataSize  packed operand B vector
- alu_operation_select  out  3  to ALU operation select
- alu_operand1  out  dataSize  to ALU operand 1
- alu_operand2  out  dataSize  to ALU operand 2
- alu_result  in  dataSize  ALU result, combinational in the same cycle
- alu_neg_flag  in  1  ALU negative flag
- alu_zero_flag  in  1  ALU zero flag
- out_valid  out  1  result vector valid
- out_ready  in  1  writeback accepts the result
- out_vec  out  lanes*dataSize  packed result vector
- out_neg_mask  out  lanes  per-lane neg flag
- out_zero_mask  out  lanes  per-lane zero flag
- out_all_zero  out  1  AND of out_zero_mask

## Operation
States:
- IDLE
  - in_ready=1.
  - ALU outputs driven to 0.
  - When in_valid is high: capture in_op, in_vec_a and in_vec_b; clear the lane index to 0; go to RUN.
- RUN
  - in_ready=0.
  - Drive alu_operation_select=op_reg, alu_operand1=a_reg[idx], alu_operand2=b_reg[idx].
  - On each edge: store alu_result, alu_neg_flag and alu_zero_flag into lane idx of the result registers; increment idx.
  - When idx==lanes-1 at the edge: go to DONE.
- DONE
  - out_valid=1.
  - ALU outputs driven to 0.
  - out_vec and the masks are held stable until out_ready.
  - On out_ready: if in_valid is also high, capture the new request and go to RUN (in_ready=out_ready in DONE); otherwise go to IDLE.

Rules:
- in_op is never interpreted: opcode 000 runs all lanes and yields zeros with the zero flags set.
- Result, flag and width handling belong entirely to the ALU; the sequencer stores exactly what it returns.
- The lane index width is clog2(lanes) and never exceeds lanes-1.
- Input vectors are sampled only at accept; later changes to them have no effect.

## Timing
- Accept edge T0 → lane k captured at edge T(k+1) → out_valid high after edge T(lanes).
- Latency: lanes+1 cycles from the accept edge to the result handshake opportunity.
- Throughput: back-to-back handshakes through DONE give one vector per lanes+1 cycles; with an idle gap it is one per lanes+2 cycles.
- in_ready is combinational from state and out_ready. No other combinational in→out paths exist except through the external ALU loop.
- Reset values: state IDLE, idx 0, out_valid 0, in_ready 1, all ALU outputs 0, out_vec 0, masks 0, out_all_zero 0.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; partial results are discarded and cleared, with no output handshake.
- out_valid is never deasserted without out_ready.

## Configuration
- VEC_SEQ_SCALAR_BCAST_EN defined:
  - Adds input port in_scalar_b (1 bit), captured at accept.
  - When in_scalar_b is set, alu_operand2 = b_reg lane 0 for every lane.
- Macro undefined: port absent; operand2 is always b_reg[idx].

## Test plan
- Add (dataSize=8, lanes=4): op=010, a lanes3..0={4,3,2,1}, b={1,1,1,1} → out_vec={5,4,3,2}, zero_mask=0000, out_valid 4 cycles after the accept edge.
- Subtract with flags: op=011, lane0 a=5 b=5, lane1 a=0 b=1, lanes2/3 a=9 b=2 → lanes={7,7,0xFF,0x00}, zero_mask=0001, neg_mask=0010, out_all_zero=0.
- Backpressure: out_ready low 3 cycles in DONE → out_vec stable, in_ready=0. Then out_ready=1 and in_valid=1 in the same cycle → handshake completes and the next op enters RUN on the same edge.
- Reset mid-RUN: assert rst_n=0 after lane 1 is captured → in_ready=1, out_valid=0, out_vec=0 immediately. A fresh op after release produces a correct full result.
- Broadcast, macro defined: op=110, a={1,1,1,1}, b={7,7,7,2}, in_scalar_b=1 → out_vec={4,4,4,4}. With in_scalar_b=0, or the macro undefined → {0x80,0x80,0x80,0x04}.

Source files
------------

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: takes one vector operation from issue and feeds its lanes
// through the external scalar ALU one per cycle. The per-lane results and flags are
// collected, and the result vector goes to writeback over a valid/ready handshake.
// Optional feature: define VEC_SEQ_SCALAR_BCAST_EN to add in_scalar_b. When that
// input is set, lane 0 of operand B is broadcast to every lane.
module vector_alu_sequencer #(
    parameter int dataSize = 8,
    parameter int lanes    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [lanes*dataSize-1:0] in_vec_a,
    input  logic [lanes*dataSize-1:0] in_vec_b,
`ifdef VEC_SEQ_SCALAR_BCAST_EN
    input  logic                      in_scalar_b,
`endif
    output logic [2:0]                alu_operation_select,
    output logic [dataSize-1:0]       alu_operand1,
    output logic [dataSize-1:0]       alu_operand2,
    input  logic [dataSize-1:0]       alu_result,
    input  logic                      alu_neg_flag,
    input  logic                      alu_zero_flag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lanes*dataSize-1:0] out_vec,
    output logic [lanes-1:0]          out_neg_mask,
    output logic [lanes-1:0]          out_zero_mask,
    output logic                      out_all_zero
);

    localparam int IdxW = $clog2(lanes);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state_q;
    logic [IdxW-1:0]           laneIdx_q;
    logic [IdxW-1:0]           laneIdx_d;
    logic [2:0]                opReg_q;
    logic [lanes*dataSize-1:0] vecA_q;
    logic [lanes*dataSize-1:0] vecB_q;
    logic [lanes*dataSize-1:0] result_q;
    logic [lanes-1:0]          negMask_q;
    logic [lanes-1:0]          zeroMask_q;
    logic                      outValid_q;
`ifdef VEC_SEQ_SCALAR_BCAST_EN
    logic                      scalarB_q;
`endif

    logic                      accept;
    logic                      lastLane;
    logic                      running;
    logic [dataSize-1:0]       laneA;
    logic [dataSize-1:0]       laneB;

    // A new request can be taken while idle, or in the same cycle that writeback drains DONE.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign lastLane  = (laneIdx_q == IdxW'(lanes - 1));
    assign laneIdx_d = laneIdx_q + IdxW'(1);
    assign running   = (state_q == RUN);

    // Select the operand elements for the lane currently being walked.
    always_comb begin
        laneA = '0;
        laneB = '0;
        for (int i = 0; i < lanes; i++) begin
            if (laneIdx_q == IdxW'(i)) begin
                laneA = vecA_q[i*dataSize +: dataSize];
                laneB = vecB_q[i*dataSize +: dataSize];
            end
        end
    end

    // The ALU sees real operands only while lanes are being walked. At other times it sees zeros.
    always_comb begin
        alu_operation_select = '0;
        alu_operand1         = '0;
        alu_operand2         = '0;
        if (running) begin
            alu_operation_select = opReg_q;
            alu_operand1         = laneA;
`ifdef VEC_SEQ_SCALAR_BCAST_EN
            alu_operand2         = scalarB_q ? vecB_q[dataSize-1:0] : laneB;
`else
            alu_operand2         = laneB;
`endif
        end
    end

    assign out_valid     = outValid_q;
    assign out_vec       = result_q;
    assign out_neg_mask  = negMask_q;
    assign out_zero_mask = zeroMask_q;
    assign out_all_zero  = &zeroMask_q;

    // Sequencer FSM: capture on accept, store one ALU lane per cycle, hold the result until drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            laneIdx_q  <= '0;
            opReg_q    <= '0;
            vecA_q     <= '0;
            vecB_q     <= '0;
            result_q   <= '0;
            negMask_q  <= '0;
            zeroMask_q <= '0;
            outValid_q <= 1'b0;
`ifdef VEC_SEQ_SCALAR_BCAST_EN
            scalarB_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                opReg_q    <= in_op;
                vecA_q     <= in_vec_a;
                vecB_q     <= in_vec_b;
                laneIdx_q  <= '0;
                state_q    <= RUN;
                outValid_q <= 1'b0;
`ifdef VEC_SEQ_SCALAR_BCAST_EN
                scalarB_q  <= in_scalar_b;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    RUN: begin
                        for (int i = 0; i < lanes; i++) begin
                            if (laneIdx_q == IdxW'(i)) begin
                                result_q[i*dataSize +: dataSize] <= alu_result;
                                negMask_q[i]                     <= alu_neg_flag;
                                zeroMask_q[i]                    <= alu_zero_flag;
                            end
                        end
                        if (lastLane) begin
                            laneIdx_q  <= '0;
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                        end else begin
                            laneIdx_q  <= laneIdx_d;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            outValid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: directed bench for vector_alu_sequencer.
// It includes a behavioural scalar ALU on the loop side and a transaction-level
// reference model. The reference model is checked every cycle against the DUT.
module tb_vector_alu_sequencer;

    localparam int DW = 8;
    localparam int LN = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_op;
    logic [LN*DW-1:0] in_vec_a;
    logic [LN*DW-1:0] in_vec_b;
    logic           in_scalar_b;
    logic [2:0]     alu_operation_select;
    logic [DW-1:0]  alu_operand1;
    logic [DW-1:0]  alu_operand2;
    logic [DW-1:0]  alu_result;
    logic           alu_neg_flag;
    logic           alu_zero_flag;
    logic           out_valid;
    logic           out_ready;
    logic [LN*DW-1:0] out_vec;
    logic [LN-1:0]  out_neg_mask;
    logic [LN-1:0]  out_zero_mask;
    logic           out_all_zero;

    int vectors = 0;
    int miscompares = 0;

    vector_alu_sequencer #(.dataSize(DW), .lanes(LN)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_op                (in_op),
        .in_vec_a             (in_vec_a),
        .in_vec_b             (in_vec_b),
`ifdef VEC_SEQ_SCALAR_BCAST_EN
        .in_scalar_b          (in_scalar_b),
`endif
        .alu_operation_select (alu_operation_select),
        .alu_operand1         (alu_operand1),
        .alu_operand2         (alu_operand2),
        .alu_result           (alu_result),
        .alu_neg_flag         (alu_neg_flag),
        .alu_zero_flag        (alu_zero_flag),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_vec              (out_vec),
        .out_neg_mask         (out_neg_mask),
        .out_zero_mask        (out_zero_mask),
        .out_all_zero         (out_all_zero)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference scalar ALU behaviour, shared by the loop-side ALU and the model.
    function automatic logic [DW-1:0] aluRef(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
        case (op)
            3'b001:  return x & y;
            3'b010:  return x + y;
            3'b011:  return x - y;
            3'b100:  return x | y;
            3'b101:  return x ^ y;
            3'b110:  return x << y[2:0];
            3'b111:  return x >> y[2:0];
            default: return '0;
        endcase
    endfunction

    // External ALU closing the loop combinationally.
    assign alu_result    = aluRef(alu_operation_select, alu_operand1, alu_operand2);
    assign alu_neg_flag  = alu_result[DW-1];
    assign alu_zero_flag = (alu_result == '0);

    function automatic logic [DW-1:0] laneOf(input logic [LN*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model state: the operation in flight and how many cycles have passed since it was accepted.
    logic           mPending;
    int             mCount;
    logic [2:0]     mOp;
    logic [LN*DW-1:0] mA;
    logic [LN*DW-1:0] mB;
    logic           mSb;

    // Whole-vector expectation for the operation the model holds.
    task automatic modelResult(output logic [LN*DW-1:0] vec, output logic [LN-1:0] neg, output logic [LN-1:0] zero);
        logic [DW-1:0] r;
        vec = '0; neg = '0; zero = '0;
        for (int k = 0; k < LN; k++) begin
            r = aluRef(mOp, laneOf(mA, k), (mSb ? laneOf(mB, 0) : laneOf(mB, k)));
            vec[k*DW +: DW] = r;
            neg[k]  = r[DW-1];
            zero[k] = (r == '0);
        end
    endtask

    // Model advance: accept when free or when draining, one lane per cycle, then wait for writeback.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPending <= 1'b0;
            mCount   <= 0;
        end else if (!mPending || (mCount >= LN && out_ready)) begin
            if (in_valid) begin
                mPending <= 1'b1;
                mCount   <= 0;
                mOp      <= in_op;
                mA       <= in_vec_a;
                mB       <= in_vec_b;
`ifdef VEC_SEQ_SCALAR_BCAST_EN
                mSb      <= in_scalar_b;
`else
                mSb      <= 1'b0;
`endif
            end else begin
                mPending <= 1'b0;
            end
        end else if (mCount < LN) begin
            mCount <= mCount + 1;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [LN*DW-1:0] ev;
        logic [LN-1:0]    en;
        logic [LN-1:0]    ez;
        if (!mPending) begin
            check("idle.in_ready", 64'(in_ready), 64'd1);
            check("idle.out_valid", 64'(out_valid), 64'd0);
            check("idle.alu_op", 64'(alu_operation_select), 64'd0);
            check("idle.operand1", 64'(alu_operand1), 64'd0);
            check("idle.operand2", 64'(alu_operand2), 64'd0);
        end else if (mCount < LN) begin
            check("run.in_ready", 64'(in_ready), 64'd0);
            check("run.out_valid", 64'(out_valid), 64'd0);
            check("run.alu_op", 64'(alu_operation_select), 64'(mOp));
            check("run.operand1", 64'(alu_operand1), 64'(laneOf(mA, mCount)));
            check("run.operand2", 64'(alu_operand2), 64'(mSb ? laneOf(mB, 0) : laneOf(mB, mCount)));
        end else begin
            modelResult(ev, en, ez);
            check("done.out_valid", 64'(out_valid), 64'd1);
            check("done.in_ready", 64'(in_ready), 64'(out_ready));
            check("done.alu_op", 64'(alu_operation_select), 64'd0);
            check("done.operand1", 64'(alu_operand1), 64'd0);
            check("done.out_vec", 64'(out_vec), 64'(ev));
            check("done.neg_mask", 64'(out_neg_mask), 64'(en));
            check("done.zero_mask", 64'(out_zero_mask), 64'(ez));
            check("done.all_zero", 64'(out_all_zero), 64'(&ez));
        end
    end

    // Issue one request; returns just after its accept edge with the input vectors scrambled.
    task automatic applyStimulus(input logic [2:0] op, input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, input logic sb);
        int guard;
        in_op = op; in_vec_a = a; in_vec_b = b; in_scalar_b = sb;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept.timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec_a = {$urandom, $urandom};
        in_vec_b = {$urandom, $urandom};
        in_op    = 3'($urandom);
    endtask

    // Count edges from the accept edge until out_valid rises, bounded.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) check("result.timeout", 64'd0, 64'd1);
    endtask

    task automatic checkOutput(input string name, input logic [LN*DW-1:0] v, input logic [LN-1:0] zm, input logic [LN-1:0] nm, input logic az);
        check({name, ".vec"}, 64'(out_vec), 64'(v));
        check({name, ".zero"}, 64'(out_zero_mask), 64'(zm));
        check({name, ".neg"}, 64'(out_neg_mask), 64'(nm));
        check({name, ".allzero"}, 64'(out_all_zero), 64'(az));
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain.out_valid", 64'(out_valid), 64'd0);
    endtask

    // Directed test sequence.
    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_vec_a = '0; in_vec_b = '0; in_scalar_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset", '0, '0, '0, 1'b0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with latency check.
        applyStimulus(3'b010, 32'h04030201, 32'h01010101, 1'b0);
        waitResult(cyc);
        check("add.latency", 64'(cyc), 64'd4);
        checkOutput("add", 32'h05040302, 4'b0000, 4'b0000, 1'b0);
        drain();

        // Subtract with flags.
        applyStimulus(3'b011, 32'h09090005, 32'h02020105, 1'b0);
        waitResult(cyc);
        checkOutput("sub", 32'h0707FF00, 4'b0001, 4'b0010, 1'b0);
        drain();

        // Opcode 000 still walks every lane.
        applyStimulus(3'b000, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        waitResult(cyc);
        checkOutput("op0", 32'h00000000, 4'b1111, 4'b0000, 1'b1);
        drain();

        // Backpressure, then a drain and an accept on the same edge.
        applyStimulus(3'b010, 32'h0A141E28, 32'h01020304, 1'b0);
        waitResult(cyc);
        for (int i = 0; i < 3; i++) begin
            check("bp.out_vec", 64'(out_vec), 64'h0B16212C);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_op = 3'b011; in_vec_a = 32'h09090005; in_vec_b = 32'h02020105;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_vec_a = 32'hFFFFFFFF;
        check("bp.out_valid", 64'(out_valid), 64'd0);
        check("bp.run_op", 64'(alu_operation_select), 64'd3);
        waitResult(cyc);
        check("bp.latency", 64'(cyc), 64'd4);
        checkOutput("bp.sub", 32'h0707FF00, 4'b0001, 4'b0010, 1'b0);
        drain();

        // Reset after lane 1 is captured.
        applyStimulus(3'b010, 32'h11223344, 32'h01010101, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.operand1", 64'(alu_operand1), 64'd0);
        checkOutput("rst", '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(3'b011, 32'h80000010, 32'h00000020, 1'b0);
        waitResult(cyc);
        checkOutput("postrst", 32'h800000F0, 4'b0110, 4'b1001, 1'b0);
        drain();

        // Shift with the scalar-broadcast request.
        applyStimulus(3'b110, 32'h01010101, 32'h07070702, 1'b1);
        waitResult(cyc);
`ifdef VEC_SEQ_SCALAR_BCAST_EN
        checkOutput("bcast", 32'h04040404, 4'b0000, 4'b0000, 1'b0);
`else
        checkOutput("bcast", 32'h80808004, 4'b0000, 4'b1110, 1'b0);
`endif
        drain();

        // Shift without broadcast.
        applyStimulus(3'b110, 32'h01010101, 32'h07070702, 1'b0);
        waitResult(cyc);
        checkOutput("shl", 32'h80808004, 4'b0000, 4'b1110, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
